v2_peak_detector: RTL and testbench
===================================

# v2_peak_detector

Downstream stage of the v2 trapezoidal shaping filter. Consumes the filter's signed output stream one sample per clock and detects pulses as threshold excursions. For each pulse it reports the maximum amplitude and the timestamp of that maximum through a 2-entry valid/ready output queue, then applies a programmable hold-off.

## Interface
Parameters:
- DATA_W, SIZE_FILTER_DATA+3, width of the filter samples and of threshold/amplitude (two's complement).
- TS_W, 32, width of the timestamp counter.
- HOLDOFF, 16, number of cycles ignored after each detected pulse (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- filter_data  in  DATA_W  signed filter sample, valid every cycle.
- threshold  in  DATA_W  signed detection threshold, quasi-static.
- peak_ready  in  1  consumer accepts the head entry.
- peak_valid  out  1  queue non-empty.
- peak_amp  out  DATA_W  signed maximum of the head event.
- peak_time  out  TS_W  timestamp of the head event's maximum.
- drop_cnt  out  8  saturating count of events lost to a full queue.
- busy  out  1  FSM not in IDLE.

## Operation
- Input register: d0 <= filter_data and d0_ts <= ts_cnt on every edge. ts_cnt resets to 0, increments every edge and wraps modulo 2^TS_W.
- All comparisons are signed.
- FSM states IDLE, RISE, HOLD:
  - IDLE: if d0 > threshold, go to RISE with max <= d0 and max_ts <= d0_ts.
  - RISE: if d0 > threshold, update max/max_ts only when d0 > max (ties keep the earliest). If d0 <= threshold, push {max, max_ts}, load hold_cnt <= HOLDOFF-1 and go to HOLD. The terminating sample is never part of the pulse.
  - HOLD: input is ignored. hold_cnt decrements to 0, then the FSM goes to IDLE. A sample above threshold on the IDLE-entry cycle is not detected until the next cycle in IDLE.
- Queue: 2-entry FIFO.
  - Pop occurs when peak_valid && peak_ready.
  - If a push arrives while the FIFO is full, the push is evaluated after the same-cycle pop. Full with a simultaneous pop therefore accepts the push; full without a pop drops the event and increments drop_cnt, which saturates at 255.
  - peak_amp/peak_time show the head entry and hold stable while peak_valid && !peak_ready.
- Reset (including mid-pulse) clears the FSM to IDLE, empties the FIFO, and zeroes ts_cnt, drop_cnt, max, d0.

## Timing
- Reset values: peak_valid 0, peak_amp 0, peak_time 0, drop_cnt 0, busy 0.
- A sample presented before edge n is registered at edge n and evaluated by the FSM at edge n+1.
- Terminating sample at edge n causes the push at edge n+1. peak_valid is high after edge n+1, a latency of 2 cycles.
- The timestamp of a sample is the ts_cnt value before the edge that registers it. The first registered sample after reset release has ts 0.
- busy is high from the edge entering RISE through the last HOLD cycle.
- After a push, the earliest new detection is HOLDOFF+1 edges later.

## Configuration
- V2_PEAK_TIMESTAMP_EN defined: ts_cnt, d0_ts and max_ts exist; FIFO entries are DATA_W+TS_W bits.
- Undefined: those registers are not built, peak_time is tied to 0 and FIFO entries are DATA_W bits. All other behaviour is identical.

## Structure
- Package package_settings_v2 holds DATA_W-related constants (SIZE_FILTER_DATA), the default HOLDOFF, and the enum typedef peak_state_t {IDLE, RISE, HOLD}.
- One sub-module: v2_peak_fifo, a 2-entry synchronous FIFO with push/pop/full/empty and an entry width parameter. FSM, counters and the input register stay in the top.

## Test plan
- Single pulse: threshold=100, HOLDOFF=16, samples 0,50,150,300,250,90 registered with ts 10..15. Expect one event amp=300, time=13, peak_valid rising 2 cycles after the 90 sample is registered.
- Tie/negative: threshold=-50, samples -40,-20,-20,-60. Expect amp=-20 at the time of the first -20.
- Hold-off: pulse (peak 200) ending at ts 20, then a second pulse starting at ts 25 with HOLDOFF=16. Expect the second pulse to be ignored: 1 event, busy high through ts 37.
- Back-pressure: peak_ready=0 and three well-separated pulses with amps 120,130,140. Expect the FIFO to hold 120 then 130, drop_cnt=1; raising peak_ready pops 120 then 130.
- Full plus pop: FIFO full and peak_ready=1 on the same edge as a push. Expect the push to be accepted and drop_cnt unchanged.
- Reset mid-pulse: assert reset while in RISE with max=500. Expect peak_valid 0 and busy 0 at once, no event after release, and ts restarting at 0.

Source files
------------

// File: rtl/v2_peak_detector_pkg.sv
// Shared settings for the v2 shaping / peak-detection chain.
package package_settings_v2;
  localparam int unsigned SIZE_FILTER_DATA     = 13;
  localparam int unsigned PEAK_HOLDOFF_DEFAULT = 16;

  typedef enum logic [1:0] {IDLE, RISE, HOLD} peak_state_t;
endpackage

// File: rtl/v2_peak_detector_fifo.sv
// Two-entry synchronous FIFO; a push while full is accepted only if a pop frees a slot on the same edge.
module v2_peak_fifo #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             do_pop;
  logic             do_push;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      // When full, wr_ptr == rd_ptr, so a pop+push overwrites the slot being released.
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/v2_peak_detector.sv
// Threshold-excursion peak detector with hold-off and a 2-entry event queue.
// Define V2_PEAK_TIMESTAMP_EN to build the timestamp path; otherwise peak_time is tied to 0.
module v2_peak_detector
  import package_settings_v2::*;
#(
  parameter int unsigned DATA_W  = SIZE_FILTER_DATA + 3,
  parameter int unsigned TS_W    = 32,
  parameter int unsigned HOLDOFF = PEAK_HOLDOFF_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] filter_data,
  input  logic [DATA_W-1:0] threshold,
  input  logic              peak_ready,
  output logic              peak_valid,
  output logic [DATA_W-1:0] peak_amp,
  output logic [TS_W-1:0]   peak_time,
  output logic [7:0]        drop_cnt,
  output logic              busy
);
  localparam int unsigned HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
`ifdef V2_PEAK_TIMESTAMP_EN
  localparam int unsigned ENTRY_W = DATA_W + TS_W;
`else
  localparam int unsigned ENTRY_W = DATA_W;
`endif

  peak_state_t              state_q, state_d;
  logic signed [DATA_W-1:0] d0, thr, max_q, max_d;
  logic [HC_W-1:0]          hold_q, hold_d;
  logic                     take, push, pop, full, empty;
  logic [ENTRY_W-1:0]       push_data, pop_data;

  assign thr = threshold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      d0      <= '0;
      max_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      d0      <= filter_data;
      max_q   <= max_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    hold_d  = hold_q;
    take    = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: if (d0 > thr) begin
        state_d = RISE;
        take    = 1'b1;
      end
      RISE: if (d0 > thr) begin
        take = (d0 > max_q);
      end else begin
        push    = 1'b1;
        hold_d  = HC_W'(HOLDOFF - 1);
        state_d = HOLD;
      end
      HOLD: if (hold_q == '0) state_d = IDLE;
            else hold_d = hold_q - HC_W'(1);
      default: state_d = IDLE;
    endcase
    if (take) max_d = d0;
  end

`ifdef V2_PEAK_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt, d0_ts, max_ts;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt <= '0;
      d0_ts  <= '0;
      max_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      d0_ts  <= ts_cnt;
      if (take) max_ts <= d0_ts;
    end
  end

  assign push_data = {max_q, max_ts};
  assign peak_time = pop_data[TS_W-1:0];
`else
  assign push_data = max_q;
  assign peak_time = '0;
`endif

  assign peak_amp   = pop_data[ENTRY_W-1 -: DATA_W];
  assign peak_valid = !empty;
  assign pop        = peak_valid && peak_ready;
  assign busy       = (state_q != IDLE);

  v2_peak_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .pop_data (pop_data),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt <= '0;
    else if (push && full && !pop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
endmodule

// File: tb/tb_v2_peak_detector.sv
// Self-checking bench for v2_peak_detector: directed pulses plus a randomized run against an event-level model.
module tb_v2_peak_detector;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TS_W    = 32;
  localparam int unsigned HOLDOFF = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] filter_data = '0;
  logic [DATA_W-1:0] threshold = 16'd100;
  logic              peak_ready = 1'b0;
  logic              peak_valid;
  logic [DATA_W-1:0] peak_amp;
  logic [TS_W-1:0]   peak_time;
  logic [7:0]        drop_cnt;
  logic              busy;

  v2_peak_detector #(
    .DATA_W (DATA_W),
    .TS_W   (TS_W),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .filter_data(filter_data),
    .threshold  (threshold),
    .peak_ready (peak_ready),
    .peak_valid (peak_valid),
    .peak_amp   (peak_amp),
    .peak_time  (peak_time),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic longint exp_ts(input longint t);
`ifdef V2_PEAK_TIMESTAMP_EN
    return t;
`else
    return 0;
`endif
  endfunction

  // Event-level model: pulses are runs of samples above threshold, detection is
  // blocked until HOLDOFF+1 edges after each reported event.
  typedef struct { int amp; longint ts; } ev_t;
  ev_t         mq[$];
  int          m_drop;
  bit          m_busy;
  int          m_pv;
  longint      m_pts;
  logic [31:0] m_ts;
  longint      m_edge, m_free_at;
  bit          m_in_pulse;
  int          m_max;
  longint      m_max_ts;

  task automatic model_step();
    bit  push_ev;
    ev_t ev;
    int  thr;
    if (!reset) begin
      mq.delete();
      m_drop = 0; m_busy = 0; m_pv = 0; m_pts = 0; m_ts = 0;
      m_edge = 0; m_free_at = 0; m_in_pulse = 0; m_max = 0; m_max_ts = 0;
      return;
    end
    thr = $signed(threshold);
    push_ev = 0;
    if (m_edge >= m_free_at) begin
      if (m_pv > thr) begin
        if (!m_in_pulse || m_pv > m_max) begin
          m_max = m_pv; m_max_ts = m_pts;
        end
        m_in_pulse = 1;
      end else if (m_in_pulse) begin
        push_ev = 1;
        ev.amp = m_max; ev.ts = m_max_ts;
        m_in_pulse = 0;
        m_free_at = m_edge + HOLDOFF + 1;
      end
    end
    if (mq.size() > 0 && peak_ready) void'(mq.pop_front());
    if (push_ev) begin
      if (mq.size() < 2) mq.push_back(ev);
      else if (m_drop < 255) m_drop++;
    end
    m_busy = m_in_pulse || (m_edge < m_free_at - 1);
    m_pv  = $signed(filter_data);
    m_pts = longint'(m_ts);
    m_ts  = m_ts + 32'd1;
    m_edge++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check("rst_valid", longint'(peak_valid), 0);
      check("rst_amp", longint'(peak_amp), 0);
      check("rst_time", longint'(peak_time), 0);
      check("rst_drop", longint'(drop_cnt), 0);
      check("rst_busy", longint'(busy), 0);
    end else begin
      check("valid", longint'(peak_valid), longint'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("amp", longint'($signed(peak_amp)), longint'(mq[0].amp));
        check("time", longint'(peak_time), exp_ts(mq[0].ts));
      end
      check("drop", longint'(drop_cnt), longint'(m_drop));
      check("busy", longint'(busy), longint'(m_busy));
    end
  end

  task automatic drv(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      filter_data = DATA_W'(v);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int thr);
    reset = 1'b0;
    filter_data = '0;
    peak_ready = 1'b0;
    threshold = DATA_W'(thr);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic pop_one();
    peak_ready = 1'b1;
    drv(0, 1);
    peak_ready = 1'b0;
  endtask

  initial begin
    do_reset(100);

    // Single pulse: samples 0,50,150,300,250,90 at ts 10..15
    drv(0, 11);
    drv(50, 1); drv(150, 1); drv(300, 1); drv(250, 1); drv(90, 1);
    check("single_valid_pre", longint'(peak_valid), 0);
    drv(0, 1);
    check("single_valid", longint'(peak_valid), 1);
    check("single_amp", longint'($signed(peak_amp)), 300);
    check("single_time", longint'(peak_time), exp_ts(13));
    check("single_busy", longint'(busy), 1);
    drv(0, 20);
    pop_one();
    check("single_drained", longint'(peak_valid), 0);

    // Tie / negative threshold
    do_reset(100);
    drv(-100, 3);
    threshold = DATA_W'(-50);
    drv(-40, 1); drv(-20, 1); drv(-20, 1); drv(-60, 1);
    drv(-100, 1);
    check("tie_amp", longint'($signed(peak_amp)), -20);
    check("tie_time", longint'(peak_time), exp_ts(4));
    drv(-100, 20);
    pop_one();

    // Hold-off: second pulse inside hold-off is ignored
    do_reset(100);
    drv(0, 18); drv(150, 1); drv(200, 1); drv(0, 5); drv(150, 6); drv(0, 6);
    check("hold_busy_37", longint'(busy), 1);
    drv(0, 1);
    check("hold_busy_38", longint'(busy), 0);
    check("hold_amp", longint'($signed(peak_amp)), 200);
    check("hold_time", longint'(peak_time), exp_ts(19));
    drv(0, 20);
    pop_one();
    check("hold_one_event", longint'(peak_valid), 0);

    // Back-pressure: third event dropped
    do_reset(100);
    drv(0, 20);
    drv(120, 2); drv(0, 30);
    drv(130, 2); drv(0, 30);
    drv(140, 2); drv(0, 30);
    check("bp_drop", longint'(drop_cnt), 1);
    check("bp_head0", longint'($signed(peak_amp)), 120);
    pop_one();
    check("bp_head1", longint'($signed(peak_amp)), 130);
    pop_one();
    check("bp_empty", longint'(peak_valid), 0);

    // Full FIFO with a pop on the push edge
    do_reset(100);
    drv(0, 5);
    drv(110, 2); drv(0, 25);
    drv(111, 2); drv(0, 25);
    drv(112, 2); drv(0, 1);
    peak_ready = 1'b1;
    drv(0, 1);
    peak_ready = 1'b0;
    check("fp_drop", longint'(drop_cnt), 0);
    check("fp_head", longint'($signed(peak_amp)), 111);
    pop_one();
    check("fp_tail", longint'($signed(peak_amp)), 112);
    drv(0, 20);
    pop_one();

    // Reset mid-pulse
    do_reset(100);
    drv(0, 3); drv(500, 3);
    check("mid_busy", longint'(busy), 1);
    reset = 1'b0;
    filter_data = '0;
    #1;
    check("mid_rst_valid", longint'(peak_valid), 0);
    check("mid_rst_busy", longint'(busy), 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    drv(0, 4); drv(150, 1); drv(0, 2);
    check("mid_after_amp", longint'($signed(peak_amp)), 150);
    check("mid_after_time", longint'(peak_time), exp_ts(4));
    drv(0, 20);
    pop_one();
    check("mid_no_stale", longint'(peak_valid), 0);

    // Randomized run
    do_reset(60);
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) threshold = DATA_W'(int'($urandom_range(0, 200)) - 50);
      if (c == 2000) begin
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
      end
      if ($urandom_range(0, 9) < 3) filter_data = DATA_W'(int'($urandom_range(0, 700)) - 300);
      peak_ready = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
